seq_alu: RTL

Parametrised multi-cycle ALU for the ARM datapath. It executes the same eight operations as the single-cycle ALU (ADD, SUB, AND, ORR, EOR, MUL, UMULL, SMULL) at any operand width. Results and flags are registered behind a start/busy/done handshake. ADD/SUB/logic complete in one cycle; all multiplies use an iterative shift-add unit (one multiplier bit per cycle), so no combinational WIDTH×WIDTH multiplier sits in the datapath. Sits between the register-file read stage and the multicycle control FSM, which stalls on `busy`.

---
 rtl/seq_alu_if.sv | 14 +
 rtl/seq_alu.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done handshake, operands and registered results of seq_alu
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result2;
  logic [3:0]       ALUFlags;
  modport master(output start, ALUControl, a, b, input busy, done, Result, Result2, ALUFlags);
  modport slave(input start, ALUControl, a, b, output busy, done, Result, Result2, ALUFlags);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, single-cycle add/sub/logic, shift-add multiplies one bit per cycle
module seq_alu #(parameter int WIDTH = 32) (
  input logic   clk,
  input logic   reset,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MULT} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, nxt, prod;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH-1:0]   res_q, res_d, res2_q, res2_d;
  logic [WIDTH-1:0]   bb, logic_r, abs_a, abs_b;
  logic [WIDTH:0]     sum, step;
  logic [1:0]         op_q, op_d;
  logic [3:0]         flags_q, flags_d;
  logic               neg_q, neg_d, done_q, done_d, is_sub, is_smull, ovf, arith;
  // datapath: adder, logic unit, operand magnitudes and one shift-add iteration
  always_comb begin
    is_sub   = bus.ALUControl == 3'b001;
    is_smull = bus.ALUControl == 3'b111;
    arith    = bus.ALUControl[2:1] == 2'b00;
    bb       = is_sub ? ~bus.b : bus.b;
    sum      = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, is_sub};
    ovf      = (bus.a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    logic_r  = bus.ALUControl == 3'b010 ? bus.a & bus.b :
               bus.ALUControl == 3'b011 ? bus.a | bus.b : bus.a ^ bus.b;
    abs_a    = (is_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b    = (is_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    step     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    nxt      = {step, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -nxt : nxt;
  end
  // next-state: accept requests in IDLE, iterate the multiplier in MULT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    op_d     = op_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res2_d   = res2_q;
    flags_d  = flags_q;
    if (state_q == IDLE) begin
      if (bus.start && (!bus.ALUControl[2] || bus.ALUControl == 3'b100)) begin
        res_d   = arith ? sum[WIDTH-1:0] : logic_r;
        res2_d  = '0;
        flags_d = {res_d[WIDTH-1], res_d == '0, arith & sum[WIDTH], arith & ovf};
        done_d  = 1'b1;
      end else if (bus.start) begin
        state_d  = MULT;
        cnt_d    = CW'(WIDTH);
        acc_d    = '0;
        mcand_d  = abs_a;
        mplier_d = abs_b;
        op_d     = bus.ALUControl[1:0];
        neg_d    = is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end
    end else begin
      acc_d    = nxt;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        res_d   = op_q == 2'b01 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        res2_d  = op_q == 2'b01 ? '0 : prod[WIDTH-1:0];
        flags_d = {res_d[WIDTH-1], op_q == 2'b01 ? prod[WIDTH-1:0] == '0 : prod == '0, 2'b00};
      end
    end
  end
  // state and result registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res2_q   <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res2_q   <= res2_d;
      flags_q  <= flags_d;
    end
  assign bus.busy     = state_q == MULT;
  assign bus.done     = done_q;
  assign bus.Result   = res_q;
  assign bus.Result2  = res2_q;
  assign bus.ALUFlags = flags_q;
endmodule
